// File: rtl/tx_rd_mem_arb.sv
// Round-robin arbiter sharing one tx_rd_mem engine; requests pass through combinationally, return data is steered by an in-order tag FIFO.
// Zero-latency request/data paths; requests stall when the tag FIFO is full, and data stalls on the head requester's ready or while no tag is queued.
`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_PTR_W
`define PAYLOAD_PTR_W 16
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

module tx_rd_mem_arb #(
    parameter int NUM_SRCS        = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_SRCS-1:0]                           src_arb_req_val,
    input  logic [NUM_SRCS*`FLOW_ID_W-1:0]                src_arb_req_flowid,
    input  logic [NUM_SRCS*`PAYLOAD_PTR_W-1:0]            src_arb_req_offset,
    input  logic [NUM_SRCS*`MSG_DATA_SIZE_WIDTH-1:0]      src_arb_req_size,
    output logic [NUM_SRCS-1:0]                           arb_src_req_rdy,
    output logic                                          arb_rd_mem_req_val,
    output logic [`FLOW_ID_W-1:0]                         arb_rd_mem_req_flowid,
    output logic [`PAYLOAD_PTR_W-1:0]                     arb_rd_mem_req_offset,
    output logic [`MSG_DATA_SIZE_WIDTH-1:0]               arb_rd_mem_req_size,
    input  logic                                          rd_mem_arb_req_rdy,
    input  logic                                          rd_mem_arb_data_val,
    input  logic [`MAC_INTERFACE_W-1:0]                   rd_mem_arb_data,
    input  logic                                          rd_mem_arb_data_last,
    input  logic [`MAC_PADBYTES_W-1:0]                    rd_mem_arb_data_padbytes,
    output logic                                          arb_rd_mem_data_rdy,
    output logic [NUM_SRCS-1:0]                           arb_dst_data_val,
    output logic [`MAC_INTERFACE_W-1:0]                   arb_dst_data,
    output logic                                          arb_dst_data_last,
    output logic [`MAC_PADBYTES_W-1:0]                    arb_dst_data_padbytes,
    input  logic [NUM_SRCS-1:0]                           dst_arb_data_rdy,
    output logic [$clog2(MAX_OUTSTANDING):0]              arb_outstanding_cnt
);
    localparam int IDX_W = $clog2(NUM_SRCS);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FW    = `FLOW_ID_W;
    localparam int PW    = `PAYLOAD_PTR_W;
    localparam int SW    = `MSG_DATA_SIZE_WIDTH;

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] tag_mem_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] tag_mem_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             any_vld, fifo_full, fifo_empty, push, pop;
    logic [IDX_W-1:0] rr_win, winner, head, srch_idx;

    // Round-robin search from rr_ptr upward, wrapping at NUM_SRCS-1.
    always_comb begin
        any_vld  = 1'b0;
        rr_win   = rr_ptr_q;
        srch_idx = rr_ptr_q;
        for (int k = 0; k < NUM_SRCS; k++) begin
            if (!any_vld && src_arb_req_val[srch_idx]) begin
                any_vld = 1'b1;
                rr_win  = srch_idx;
            end
            if (srch_idx == IDX_W'(NUM_SRCS - 1)) srch_idx = '0;
            else                                  srch_idx = srch_idx + 1'b1;
        end
    end

    assign winner     = lock_vld_q ? lock_idx_q : rr_win;
    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    assign arb_rd_mem_req_val    = rst_n & any_vld & ~fifo_full;
    assign arb_rd_mem_req_flowid = src_arb_req_flowid[int'(winner)*FW +: FW];
    assign arb_rd_mem_req_offset = src_arb_req_offset[int'(winner)*PW +: PW];
    assign arb_rd_mem_req_size   = src_arb_req_size[int'(winner)*SW +: SW];
    assign arb_src_req_rdy       = (rst_n & any_vld & rd_mem_arb_req_rdy & ~fifo_full)
                                   ? (NUM_SRCS'(1) << winner) : '0;

    assign arb_rd_mem_data_rdy   = rst_n & ~fifo_empty & dst_arb_data_rdy[head];
    assign arb_dst_data_val      = (rst_n & ~fifo_empty & rd_mem_arb_data_val)
                                   ? (NUM_SRCS'(1) << head) : '0;
    assign arb_dst_data          = rd_mem_arb_data;
    assign arb_dst_data_last     = rd_mem_arb_data_last;
    assign arb_dst_data_padbytes = rd_mem_arb_data_padbytes;
    assign arb_outstanding_cnt   = cnt_q;

    assign push = arb_rd_mem_req_val & rd_mem_arb_req_rdy;
    assign pop  = rd_mem_arb_data_val & arb_rd_mem_data_rdy & rd_mem_arb_data_last;

    always_comb begin
        lock_vld_d = arb_rd_mem_req_val & ~rd_mem_arb_req_rdy;
        lock_idx_d = winner;
        rr_ptr_d   = rr_ptr_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (push) begin
            rr_ptr_d            = (winner == IDX_W'(NUM_SRCS - 1)) ? '0 : winner + 1'b1;
            tag_mem_d[wr_ptr_q] = winner;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_mem_q[i] <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            tag_mem_q  <= tag_mem_d;
        end
    end
endmodule

// File: tb/tb_tx_rd_mem_arb.sv
// Randomized bench for tx_rd_mem_arb against a queue-based model of arbitration and in-order data return.
`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_PTR_W
`define PAYLOAD_PTR_W 16
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

module tb_tx_rd_mem_arb;
    localparam int N    = 3;
    localparam int MAX  = 4;
    localparam int FW   = `FLOW_ID_W;
    localparam int PW   = `PAYLOAD_PTR_W;
    localparam int SW   = `MSG_DATA_SIZE_WIDTH;
    localparam int DW   = `MAC_INTERFACE_W;
    localparam int PADW = `MAC_PADBYTES_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      src_arb_req_val;
    logic [N*FW-1:0]   src_arb_req_flowid;
    logic [N*PW-1:0]   src_arb_req_offset;
    logic [N*SW-1:0]   src_arb_req_size;
    logic [N-1:0]      arb_src_req_rdy;
    logic              arb_rd_mem_req_val;
    logic [FW-1:0]     arb_rd_mem_req_flowid;
    logic [PW-1:0]     arb_rd_mem_req_offset;
    logic [SW-1:0]     arb_rd_mem_req_size;
    logic              rd_mem_arb_req_rdy;
    logic              rd_mem_arb_data_val;
    logic [DW-1:0]     rd_mem_arb_data;
    logic              rd_mem_arb_data_last;
    logic [PADW-1:0]   rd_mem_arb_data_padbytes;
    logic              arb_rd_mem_data_rdy;
    logic [N-1:0]      arb_dst_data_val;
    logic [DW-1:0]     arb_dst_data;
    logic              arb_dst_data_last;
    logic [PADW-1:0]   arb_dst_data_padbytes;
    logic [N-1:0]      dst_arb_data_rdy;
    logic [$clog2(MAX):0] arb_outstanding_cnt;

    always #5 clk = ~clk;

    tx_rd_mem_arb #(.NUM_SRCS(N), .MAX_OUTSTANDING(MAX)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .src_arb_req_val          (src_arb_req_val),
        .src_arb_req_flowid       (src_arb_req_flowid),
        .src_arb_req_offset       (src_arb_req_offset),
        .src_arb_req_size         (src_arb_req_size),
        .arb_src_req_rdy          (arb_src_req_rdy),
        .arb_rd_mem_req_val       (arb_rd_mem_req_val),
        .arb_rd_mem_req_flowid    (arb_rd_mem_req_flowid),
        .arb_rd_mem_req_offset    (arb_rd_mem_req_offset),
        .arb_rd_mem_req_size      (arb_rd_mem_req_size),
        .rd_mem_arb_req_rdy       (rd_mem_arb_req_rdy),
        .rd_mem_arb_data_val      (rd_mem_arb_data_val),
        .rd_mem_arb_data          (rd_mem_arb_data),
        .rd_mem_arb_data_last     (rd_mem_arb_data_last),
        .rd_mem_arb_data_padbytes (rd_mem_arb_data_padbytes),
        .arb_rd_mem_data_rdy      (arb_rd_mem_data_rdy),
        .arb_dst_data_val         (arb_dst_data_val),
        .arb_dst_data             (arb_dst_data),
        .arb_dst_data_last        (arb_dst_data_last),
        .arb_dst_data_padbytes    (arb_dst_data_padbytes),
        .dst_arb_data_rdy         (dst_arb_data_rdy),
        .arb_outstanding_cnt      (arb_outstanding_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Model state: next-search start, pending (stalled) grant, and queue of granted requesters.
    int rr;
    int lock;
    int tagq[$];
    logic [N-1:0]  acc_mask;
    logic [FW-1:0] fid [N];
    logic [PW-1:0] off [N];
    logic [SW-1:0] siz [N];
    bit saw_full;

    task automatic pack_srcs();
        for (int i = 0; i < N; i++) begin
            src_arb_req_flowid[i*FW +: FW] = fid[i];
            src_arb_req_offset[i*PW +: PW] = off[i];
            src_arb_req_size[i*SW +: SW]   = siz[i];
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_val"},  64'(arb_rd_mem_req_val),  64'd0);
        chk({tag, "_src_rdy"},  64'(arb_src_req_rdy),     64'd0);
        chk({tag, "_dst_val"},  64'(arb_dst_data_val),    64'd0);
        chk({tag, "_data_rdy"}, 64'(arb_rd_mem_data_rdy), 64'd0);
        chk({tag, "_cnt"},      64'(arb_outstanding_cnt), 64'd0);
    endtask

    task automatic model_reset();
        rr = 0;
        lock = -1;
        tagq.delete();
        acc_mask = '0;
    endtask

    initial begin
        int  p_data, win, h;
        bit  any, full, exp_req_val, req_hs, data_hs;
        logic [N-1:0] exp_src_rdy, exp_dst_val;
        logic         exp_drdy;

        saw_full = 0;
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            fid[i] = FW'($urandom);
            off[i] = PW'($urandom);
            siz[i] = SW'($urandom);
        end
        pack_srcs();
        src_arb_req_val          = '1;
        rd_mem_arb_req_rdy       = 1'b1;
        rd_mem_arb_data_val      = 1'b1;
        rd_mem_arb_data          = '0;
        rd_mem_arb_data_last     = 1'b1;
        rd_mem_arb_data_padbytes = '0;
        dst_arb_data_rdy         = '1;
        #3;
        chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        src_arb_req_val = '0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc == 2001) rst_n = 1'b1;
            src_arb_req_val = src_arb_req_val & ~acc_mask;
            acc_mask = '0;
            for (int i = 0; i < N; i++) begin
                if (!src_arb_req_val[i] && $urandom_range(99) < 40) begin
                    src_arb_req_val[i] = 1'b1;
                    fid[i] = FW'($urandom);
                    off[i] = PW'($urandom);
                    siz[i] = SW'($urandom);
                end
            end
            pack_srcs();
            p_data = ((cyc / 300) % 2 == 1) ? 85 : 12;
            rd_mem_arb_req_rdy       = ($urandom_range(99) < 70);
            rd_mem_arb_data_val      = ($urandom_range(99) < p_data);
            rd_mem_arb_data          = {$urandom, $urandom};
            rd_mem_arb_data_last     = ($urandom_range(2) == 0);
            rd_mem_arb_data_padbytes = PADW'($urandom);
            for (int i = 0; i < N; i++) dst_arb_data_rdy[i] = ($urandom_range(99) < 75);

            if (cyc == 2000) begin
                // Reset mid-traffic with requests pending: outputs must drop at once.
                src_arb_req_val[0] = 1'b1;
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("mid_rst");
                model_reset();
                continue;
            end
            #1;

            any  = |src_arb_req_val;
            full = (tagq.size() == MAX);
            win  = 0;
            if (lock >= 0) win = lock;
            else begin
                for (int k = N - 1; k >= 0; k--)
                    if (src_arb_req_val[(rr + k) % N]) win = (rr + k) % N;
            end
            exp_req_val = any && !full;
            exp_src_rdy = (any && rd_mem_arb_req_rdy && !full) ? N'(1 << win) : '0;
            if (tagq.size() == 0) begin
                h = 0;
                exp_dst_val = '0;
                exp_drdy    = 1'b0;
            end else begin
                h = tagq[0];
                exp_dst_val = rd_mem_arb_data_val ? N'(1 << h) : '0;
                exp_drdy    = dst_arb_data_rdy[h];
            end

            chk("req_val", 64'(arb_rd_mem_req_val), 64'(exp_req_val));
            chk("src_rdy", 64'(arb_src_req_rdy), 64'(exp_src_rdy));
            if (exp_req_val) begin
                chk("req_flowid", 64'(arb_rd_mem_req_flowid), 64'(fid[win]));
                chk("req_offset", 64'(arb_rd_mem_req_offset), 64'(off[win]));
                chk("req_size",   64'(arb_rd_mem_req_size),   64'(siz[win]));
            end
            chk("dst_val",  64'(arb_dst_data_val),    64'(exp_dst_val));
            chk("data_rdy", 64'(arb_rd_mem_data_rdy), 64'(exp_drdy));
            chk("dst_data", 64'(arb_dst_data),        64'(rd_mem_arb_data));
            chk("dst_last", 64'(arb_dst_data_last),   64'(rd_mem_arb_data_last));
            chk("dst_pad",  64'(arb_dst_data_padbytes), 64'(rd_mem_arb_data_padbytes));
            chk("cnt",      64'(arb_outstanding_cnt), 64'(tagq.size()));

            req_hs  = exp_req_val && rd_mem_arb_req_rdy;
            data_hs = (tagq.size() != 0) && rd_mem_arb_data_val && dst_arb_data_rdy[h];
            if (data_hs && rd_mem_arb_data_last) void'(tagq.pop_front());
            if (req_hs) begin
                tagq.push_back(win);
                acc_mask = N'(1 << win);
                rr   = (win + 1) % N;
                lock = -1;
            end else begin
                lock = exp_req_val ? win : -1;
            end
            if (full) saw_full = 1;
        end

        chk("saw_fifo_full", 64'(saw_full), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tx_rd_mem_arb.md
TX_RD_MEM_ARB -- requirements
Module: tx_rd_mem_arb

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 2, number of payload-read requesters sharing one tx_rd_mem engine (range 2..8).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, depth of the in-order return-tag FIFO (power of two).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port src_arb_req_val  input  NUM_SRCS  per-requester request valid.
REQ-006 SHALL have port src_arb_req_flowid  input  NUM_SRCS*`FLOW_ID_W  packed flow IDs, requester i at slice i.
REQ-007 SHALL have port src_arb_req_offset  input  NUM_SRCS*`PAYLOAD_PTR_W  packed payload offsets.
REQ-008 SHALL have port src_arb_req_size  input  NUM_SRCS*`MSG_DATA_SIZE_WIDTH  packed byte counts.
REQ-009 SHALL have port arb_src_req_rdy  output  NUM_SRCS  per-requester request accept.
REQ-010 SHALL have ports arb_rd_mem_req_val/flowid/offset/size  output  1/`FLOW_ID_W/`PAYLOAD_PTR_W/`MSG_DATA_SIZE_WIDTH  request to engine; rd_mem_arb_req_rdy  input  1.
REQ-011 SHALL have ports rd_mem_arb_data_val/data/last/padbytes  input  1/`MAC_INTERFACE_W/1/`MAC_PADBYTES_W  engine data return; arb_rd_mem_data_rdy  output  1.
REQ-012 SHALL have ports arb_dst_data_val  output  NUM_SRCS; arb_dst_data/last/padbytes  output  `MAC_INTERFACE_W/1/`MAC_PADBYTES_W (broadcast); dst_arb_data_rdy  input  NUM_SRCS.
REQ-013 SHALL have port arb_outstanding_cnt  output  $clog2(MAX_OUTSTANDING)+1  requests accepted whose last beat has not been delivered.

Function
REQ-014 SHALL be val/rdy throughout: transfer occurs in a cycle where val and rdy are both high.
REQ-015 SHALL select a winner round-robin among asserted src_arb_req_val, search starting at rr_ptr, ascending index, wrapping at NUM_SRCS-1 to 0.
REQ-016 SHALL drive arb_rd_mem_req_val = (any src valid) AND tag FIFO not full; request fields = winner's slices, combinational, zero latency.
REQ-017 SHALL assert arb_src_req_rdy[i] only for the winner, and only when rd_mem_arb_req_rdy high and tag FIFO not full; all others 0.
REQ-018 SHALL lock the winner in a register while arb_rd_mem_req_val is high and not accepted; lock cleared on handshake (downstream val/fields stay stable during stall).
REQ-019 SHALL on request handshake set rr_ptr = winner+1 mod NUM_SRCS and push winner index into tag FIFO.
REQ-020 SHALL route data to the FIFO head index h: arb_dst_data_val[h] = rd_mem_arb_data_val, other valids 0; arb_rd_mem_data_rdy = dst_arb_data_rdy[h].
REQ-021 SHALL hold arb_rd_mem_data_rdy and all arb_dst_data_val low while tag FIFO empty (stray engine beats stall, not dropped).
REQ-022 SHALL pop tag FIFO on a data handshake with rd_mem_arb_data_last=1; non-last beats do not pop.
REQ-023 SHALL, on simultaneous push and pop, leave count unchanged; when FIFO full, push blocked even if a pop occurs the same cycle.
REQ-024 SHALL keep arb_outstanding_cnt equal to FIFO occupancy, 0..MAX_OUTSTANDING.

Reset
REQ-025 SHALL on rst_n low immediately clear rr_ptr=0, lock, FIFO pointers, count=0; all valid/rdy outputs 0 while reset asserted.
REQ-026 SHALL discard in-flight transactions on reset mid-operation; first cycle after release behaves as idle with empty FIFO.

Verification
REQ-027 SHALL cover: src0 and src1 request continuously, engine always ready -> grants alternate 0,1,0,1; cnt increments to 4 then requests stall.
REQ-028 SHALL cover: src1 valid, rd_mem_arb_req_rdy low 3 cycles, src0 asserts in cycle 2 -> output stays src1 fields until accept, then src0 granted.
REQ-029 SHALL cover: grants 1 then 0, engine returns 3 beats (last on 3rd) then 1 beat -> beats 1-3 to dst1, beat 4 to dst0, cnt 2->1->0.
REQ-030 SHALL cover: dst1 holds dst_arb_data_rdy low mid-burst -> arb_rd_mem_data_rdy low, no beat lost or duplicated.
REQ-031 SHALL cover: FIFO full (cnt=4), last beat accepted same cycle as pending request -> no push that cycle, push next cycle, cnt 4->3->4.
REQ-032 SHALL cover: rst_n pulsed low with cnt=2 mid-burst -> all outputs 0 immediately, cnt=0, rr_ptr=0 after release.
